fetch_pc_control: RTL

- Front end of the instruction-fetch stage: owns the program counter, drives the word-aligned fetch address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register.
- Applies hazard-unit stalls, taken-branch and jump redirects (with flush of the wrong-path fetch), and out-of-range fetch suppression.
- Provides fetch/bubble performance counters.

---
 rtl/fetch_pc_control.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_pc_control.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_control
// Description : Instruction-fetch front end. Owns the PC, drives the fetch
//               address to a combinational instruction memory, captures the
//               returned word into the IF/ID register, applies stalls,
//               branch/jump redirects with flush, out-of-range suppression,
//               and keeps fetch/bubble performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_control #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        redirect_misaligned,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  // One past the last legal byte address; 33 bits so IMEM_WORDS*4 cannot overflow.
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] bubble_q, bubble_d;

  logic        redirect;
  logic [31:0] sel_target;
  logic [31:0] aligned_target;
  logic [31:0] pc_plus4;
  logic        in_range;

  // Redirect selection: the EX-stage branch is older than the ID-stage jump, so it wins.
  always_comb begin
    redirect       = branch_taken | jump;
    sel_target     = branch_taken ? branch_target : jump_target;
    aligned_target = {sel_target[31:2], 2'b00};
    pc_plus4       = pc_q + 32'd4;
    in_range       = ({1'b0, pc_q} < IMEM_BYTES);
  end

  // Next-state for PC, IF/ID, misaligned flag and counters (redirect > stall > advance).
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    fetch_d  = fetch_q;
    bubble_d = bubble_q;
    mis_d    = redirect && (sel_target[1:0] != 2'b00);
    if (redirect) begin
      // Flush the wrong-path fetch currently at pc.
      pc_d     = aligned_target;
      instr_d  = NOP_WORD;
      pc4_d    = 32'd0;
      valid_d  = 1'b0;
      bubble_d = bubble_q + 32'd1;
    end else if (stall) begin
      // Hold everything; stalled cycles are not counted.
    end else begin
      pc_d  = pc_plus4;
      pc4_d = pc_plus4;
      if (in_range) begin
        instr_d = imem_instruction;
        valid_d = 1'b1;
        fetch_d = fetch_q + 32'd1;
      end else begin
        // Memory data is meaningless out of range; inject a bubble instead.
        instr_d  = NOP_WORD;
        valid_d  = 1'b0;
        bubble_d = bubble_q + 32'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_WORD;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      fetch_q  <= 32'd0;
      bubble_q <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      mis_q    <= mis_d;
      fetch_q  <= fetch_d;
      bubble_q <= bubble_d;
    end
  end

  assign imem_address        = pc_q;
  assign if_id_instruction   = instr_q;
  assign if_id_pc_plus4      = pc4_q;
  assign if_id_valid         = valid_q;
  assign redirect_misaligned = mis_q;
  assign fetch_count         = fetch_q;
  assign bubble_count        = bubble_q;

endmodule
`default_nettype wire
